// File: rtl/regfile_2r1w.sv
// Integer register file: 32 x DW, two combinational read ports with write bypass,
// one synchronous write port, and a per-register pending-write scoreboard for decode stalls.
module regfile_2r1w #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic            rs1_en,
    output logic [DW-1:0]   rdata1,
    input  logic [AW-1:0]   raddr2,
    input  logic            rs2_en,
    output logic [DW-1:0]   rdata2,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            stall,
    output logic [NREG-1:0] busy_vec
);

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] pending;
    logic            issue_ok;

    // Storage for x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // A register whose producer is writing back this cycle is no longer a hazard.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
            assign pending[gi] = busy_q[gi] && !(wen && (waddr == AW'(gi)));
        end
    endgenerate

    always_comb begin
        stall = 1'b0;
        if (rs1_en && (raddr1 != '0) && pending[raddr1]) stall = 1'b1;
        if (rs2_en && (raddr2 != '0) && pending[raddr2]) stall = 1'b1;
        if (iss_en && (iss_rd != '0) && pending[iss_rd]) stall = 1'b1;
    end

    assign issue_ok = iss_en && !stall && (iss_rd != '0);

    // Set is applied after clear so a new producer issued alongside a writeback stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wen) busy_d[waddr] = 1'b0;
        if (issue_ok) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdata1 = regs_q[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wen && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs_q[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wen && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: driver pushes model expectations, a negedge monitor checks them.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic        rs1_en = 1'b0;
    logic [31:0] rdata1;
    logic [4:0]  raddr2 = '0;
    logic        rs2_en = 1'b0;
    logic [31:0] rdata2;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        stall;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
        logic [31:0] bv;
    } exp_t;

    exp_t exp_q[$];

    // Architectural reference state.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_2r1w #(.DW(32), .AW(5), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rs1_en(rs1_en), .rdata1(rdata1),
        .raddr2(raddr2), .rs2_en(rs2_en), .rdata2(rdata2),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wen && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic bit m_pending(input logic [4:0] r);
        return m_busy[r] && !(wen && waddr == r);
    endfunction

    function automatic bit m_stall();
        bit s;
        s = 0;
        if (rs1_en && raddr1 != 0 && m_pending(raddr1)) s = 1;
        if (rs2_en && raddr2 != 0 && m_pending(raddr2)) s = 1;
        if (iss_en && iss_rd != 0 && m_pending(iss_rd)) s = 1;
        return s;
    endfunction

    function automatic logic [31:0] m_busyvec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 0;
        end
    endfunction

    function automatic void push_exp(input string nm);
        exp_t e;
        e.name = nm;
        e.r1 = rst_n ? m_read(raddr1) : 32'h0;
        e.r2 = rst_n ? m_read(raddr2) : 32'h0;
        e.st = rst_n ? m_stall() : 1'b0;
        e.bv = rst_n ? m_busyvec() : 32'h0;
        exp_q.push_back(e);
    endfunction

    // Called just after a rising edge; applies inputs for one cycle.
    task automatic drive(input string nm,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2,
                         input logic iss, input logic [4:0] rd);
        bit s;
        rst_n = 1'b1;
        wen = w; waddr = wa; wdata = wd;
        rs1_en = e1; raddr1 = a1;
        rs2_en = e2; raddr2 = a2;
        iss_en = iss; iss_rd = rd;
        push_exp(nm);
        s = m_stall();
        @(posedge clk);
        if (wen) m_busy[waddr] = 0;
        if (wen && waddr != 0) m_regs[waddr] = wdata;
        if (iss_en && !s && iss_rd != 0) m_busy[iss_rd] = 1;
        #1;
    endtask

    task automatic reset_cycle(input string nm, input logic [4:0] a1, input logic [4:0] a2);
        wen = 0; rs1_en = 0; rs2_en = 0; iss_en = 0;
        raddr1 = a1; raddr2 = a2;
        rst_n = 1'b0;
        m_clear();
        push_exp(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 4;
            if (rdata1 !== e.r1) begin
                errors++;
                $display("FAIL %s rdata1: got %h expected %h", e.name, rdata1, e.r1);
            end
            if (rdata2 !== e.r2) begin
                errors++;
                $display("FAIL %s rdata2: got %h expected %h", e.name, rdata2, e.r2);
            end
            if (stall !== e.st) begin
                errors++;
                $display("FAIL %s stall: got %b expected %b", e.name, stall, e.st);
            end
            if (busy_vec !== e.bv) begin
                errors++;
                $display("FAIL %s busy_vec: got %h expected %h", e.name, busy_vec, e.bv);
            end
            $display("txn %s: rd1=%h rd2=%h stall=%b busy=%h", e.name, rdata1, rdata2, stall, busy_vec);
        end
    end

    initial begin
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_cycle("reset_read_x5_x0", 5'd5, 5'd0);

        drive("wr_x7_bypass", 1, 7, 32'hDEADBEEF, 1, 7, 0, 0, 0, 0);
        drive("rd_x7_storage", 0, 0, 0, 1, 7, 0, 0, 0, 0);
        drive("wr_x0_ignored", 1, 0, 32'h12345678, 1, 0, 0, 0, 0, 0);
        drive("iss_x0_noop", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive("rd_x0_after", 0, 0, 0, 1, 0, 1, 0, 0, 0);
        drive("iss_x3", 0, 0, 0, 0, 0, 0, 0, 1, 3);
        drive("raw_x3_stall", 0, 0, 0, 1, 3, 0, 0, 0, 0);
        drive("wb_x3_clears", 1, 3, 32'h55, 1, 3, 0, 0, 0, 0);
        drive("x3_not_busy", 0, 0, 0, 1, 3, 0, 0, 0, 0);
        drive("iss_x4", 0, 0, 0, 0, 0, 0, 0, 1, 4);
        drive("waw_x4_stall", 0, 0, 0, 0, 0, 0, 0, 1, 4);
        drive("waw_x4_wb_setwins", 1, 4, 32'hA5A5, 0, 0, 0, 0, 1, 4);
        drive("x4_still_busy", 0, 0, 0, 1, 4, 0, 0, 0, 0);
        drive("iss_x9", 0, 0, 0, 0, 0, 0, 0, 1, 9);
        drive("rs2_unused_x9", 0, 0, 0, 0, 0, 0, 9, 0, 0);
        drive("both_ports_x9", 0, 0, 0, 1, 9, 1, 9, 0, 0);
        for (int i = 0; i < 5; i++) drive("idle_persist", 0, 0, 0, 0, 7, 0, 3, 0, 0);

        drive("pre_reset_wr", 1, 12, 32'hCAFEF00D, 0, 12, 0, 0, 1, 13);
        reset_cycle("mid_reset", 5'd12, 5'd7);
        drive("post_reset_rd", 0, 0, 0, 1, 12, 1, 13, 0, 0);

        for (int i = 0; i < 500; i++) begin
            logic [4:0] wa, a1, a2, rd;
            wa = (i % 3 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            a2 = (i % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            drive("rand", $urandom_range(0, 1) == 1, wa, $urandom,
                  $urandom_range(0, 1) == 1, a1, $urandom_range(0, 1) == 1, a2,
                  $urandom_range(0, 4) < 2, rd);
            if (i == 250) reset_cycle("rand_reset", a1, a2);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
